// File: rtl/signal_encoder_pkg.sv
// -----------------------------------------------------------------------------
// signal_encoder_pkg
//
// Purpose:
//   Constants and types shared by the AUX pulse-width link. The sample point,
//   pulses-per-frame count and state encodings must agree with the receiving
//   SignalDetector. Keep them in step with that block.
//
// Contents:
//   CODEC_SAMPLE_POINT  cycles from a rising edge to the detector's sample point
//   CODEC_REPEAT        pulses per frame (1 mode pulse + confirmations)
//   DEF_*               default timing for a 50 MHz clock (3 ms slots)
//   codec_state_e       FSM encoding: IDLE=0, HIGH=1, LOW=2, GAP=3
//   max_u()             elaboration-time maximum of two unsigned values
// -----------------------------------------------------------------------------
package signal_encoder_pkg;

    localparam int unsigned CODEC_SAMPLE_POINT = 75000;
    localparam int unsigned CODEC_REPEAT       = 6;

    localparam int unsigned DEF_PERIOD_CYCLES  = 150000;
    localparam int unsigned DEF_SHORT_HIGH     = 37500;
    localparam int unsigned DEF_LONG_HIGH      = 112500;
    localparam int unsigned DEF_GAP_CYCLES     = 150000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_GAP  = 2'd3
    } codec_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/signal_pulse_timer.sv
// -----------------------------------------------------------------------------
// signal_pulse_timer
//
// Purpose:
//   Loadable down-counter used to time every phase of a frame (HIGH, LOW and
//   GAP). Loading N-1 produces an expire flag in the N-th cycle after the
//   load, so a phase entered on the load edge lasts exactly N cycles.
//
// Ports:
//   clk         in   clock
//   rst_n       in   asynchronous active-low reset (count cleared to 0)
//   load        in   load strobe; takes priority over counting
//   load_value  in   W-bit value loaded on the strobe (phase length - 1)
//   expire      out  count has reached zero (last cycle of the phase)
// -----------------------------------------------------------------------------
module signal_pulse_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         expire
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (cnt_q != '0) begin
            // Saturate at zero so an idle timer simply stays expired.
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/signal_encoder.sv
// -----------------------------------------------------------------------------
// signal_encoder
//
// Purpose:
//   Transmit side of the AUX pulse-width link. Each accepted bit becomes a
//   frame of REPEAT identical pulses on AUX_OUTPUT: a long high time for 1, a
//   short high time for 0, each pulse slot PERIOD_CYCLES long, followed by
//   GAP_CYCLES of forced low. The detector samples the line SAMPLE_POINT
//   cycles after each rising edge.
//
// Ports:
//   CLOCK_50    in   the only clock
//   RESET_N     in   asynchronous assert, synchronous release, active low
//   TX_VALID    in   bit offered for transmission
//   TX_BIT      in   bit value, sampled when TX_VALID && TX_READY
//   TX_READY    out  encoder idle, can accept a bit
//   AUX_OUTPUT  out  registered pulse-width line to the detector
//   BUSY        out  frame in progress (inverse of TX_READY)
//   DONE        out  high in the final GAP cycle of a completed frame
// -----------------------------------------------------------------------------
module signal_encoder
    import signal_encoder_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = DEF_PERIOD_CYCLES,
    parameter int unsigned SAMPLE_POINT  = CODEC_SAMPLE_POINT,
    parameter int unsigned SHORT_HIGH    = DEF_SHORT_HIGH,
    parameter int unsigned LONG_HIGH     = DEF_LONG_HIGH,
    parameter int unsigned REPEAT        = CODEC_REPEAT,
    parameter int unsigned GAP_CYCLES    = DEF_GAP_CYCLES
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic TX_VALID,
    input  logic TX_BIT,
    output logic TX_READY,
    output logic AUX_OUTPUT,
    output logic BUSY,
    output logic DONE
);

    // Cycle timer wide enough for the longest phase; it is reloaded on every
    // state change, so it never has to wrap.
    localparam int unsigned CYC_W = $clog2(max_u(PERIOD_CYCLES, GAP_CYCLES));
    localparam int unsigned CNT_W = $clog2(REPEAT);

    // Timer load values are phase length minus one (expire marks the last cycle).
    localparam logic [CYC_W-1:0] LOAD_SHORT_HIGH = CYC_W'(SHORT_HIGH - 1);
    localparam logic [CYC_W-1:0] LOAD_LONG_HIGH  = CYC_W'(LONG_HIGH - 1);
    localparam logic [CYC_W-1:0] LOAD_SHORT_LOW  = CYC_W'(PERIOD_CYCLES - SHORT_HIGH - 1);
    localparam logic [CYC_W-1:0] LOAD_LONG_LOW   = CYC_W'(PERIOD_CYCLES - LONG_HIGH - 1);
    localparam logic [CYC_W-1:0] LOAD_GAP        = CYC_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_PULSE      = CNT_W'(REPEAT - 1);

    // Elaboration-time sanity of the pulse geometry. The sample point must sit
    // strictly between the two high times or the detector cannot tell them apart.
    generate
        if (!(SHORT_HIGH > 0 && SHORT_HIGH < SAMPLE_POINT &&
              SAMPLE_POINT < LONG_HIGH && LONG_HIGH < PERIOD_CYCLES)) begin : g_bad_geometry
            $error("signal_encoder: need 0 < SHORT_HIGH < SAMPLE_POINT < LONG_HIGH < PERIOD_CYCLES");
        end
        if (REPEAT < 2) begin : g_bad_repeat
            $error("signal_encoder: REPEAT must be at least 2");
        end
        if (GAP_CYCLES < 1) begin : g_bad_gap
            $error("signal_encoder: GAP_CYCLES must be at least 1");
        end
    endgenerate

    codec_state_e     state_q;
    codec_state_e     state_d;
    logic [CNT_W-1:0] pulse_cnt_q;
    logic [CNT_W-1:0] pulse_cnt_d;
    logic             bit_q;
    logic             bit_d;
    logic             aux_q;
    logic             aux_d;

    logic             tmr_load;
    logic [CYC_W-1:0] tmr_value;
    logic             tmr_expire;

    signal_pulse_timer #(
        .W (CYC_W)
    ) u_timer (
        .clk        (CLOCK_50),
        .rst_n      (RESET_N),
        .load       (tmr_load),
        .load_value (tmr_value),
        .expire     (tmr_expire)
    );

    // Next-state logic. Every transition reloads the timer with the length of
    // the phase being entered, so the timer is only ever consulted in the
    // phase it was loaded for.
    always_comb begin
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
        bit_d       = bit_q;
        tmr_load    = 1'b0;
        tmr_value   = '0;

        case (state_q)
            ST_IDLE: begin
                if (TX_VALID) begin
                    bit_d       = TX_BIT;
                    pulse_cnt_d = '0;
                    state_d     = ST_HIGH;
                    tmr_load    = 1'b1;
                    tmr_value   = TX_BIT ? LOAD_LONG_HIGH : LOAD_SHORT_HIGH;
                end
            end

            ST_HIGH: begin
                if (tmr_expire) begin
                    state_d   = ST_LOW;
                    tmr_load  = 1'b1;
                    tmr_value = bit_q ? LOAD_LONG_LOW : LOAD_SHORT_LOW;
                end
            end

            ST_LOW: begin
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    if (pulse_cnt_q == LAST_PULSE) begin
                        state_d   = ST_GAP;
                        tmr_value = LOAD_GAP;
                    end else begin
                        pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
                        state_d     = ST_HIGH;
                        tmr_value   = bit_q ? LOAD_LONG_HIGH : LOAD_SHORT_HIGH;
                    end
                end
            end

            ST_GAP: begin
                if (tmr_expire) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The line is a straight registered copy of "next state is HIGH", so
        // it rises on the edge that leaves IDLE and is glitch free.
        aux_d = (state_d == ST_HIGH);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            pulse_cnt_q <= '0;
            bit_q       <= 1'b0;
            aux_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pulse_cnt_q <= pulse_cnt_d;
            bit_q       <= bit_d;
            aux_q       <= aux_d;
        end
    end

    assign AUX_OUTPUT = aux_q;
    assign TX_READY   = (state_q == ST_IDLE);
    assign BUSY       = (state_q != ST_IDLE);
    // Decoded from the registered state and timer, so a reset mid-frame
    // (which forces IDLE) can never produce a DONE.
    assign DONE       = (state_q == ST_GAP) && tmr_expire;

endmodule

// File: tb/tb_signal_encoder.sv
// -----------------------------------------------------------------------------
// tb_signal_encoder
//
// Drives signal_encoder with short simulation timing (PERIOD=40, SAMPLE=20,
// SHORT=10, LONG=30, REPEAT=6, GAP=40). Expected frames are queued when a bit
// is offered; a line monitor measures each finished frame and queues what it
// saw, and each test pops both and compares.
// -----------------------------------------------------------------------------
module tb_signal_encoder;

    localparam int PERIOD = 40;
    localparam int SAMPLE = 20;
    localparam int SHORT  = 10;
    localparam int LONG   = 30;
    localparam int REP    = 6;
    localparam int GAP    = 40;
    localparam int FRAME  = REP * PERIOD + GAP;   // cycles from first rise through DONE

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic tx_valid = 1'b0;
    logic tx_bit   = 1'b0;
    logic tx_ready;
    logic aux_out;
    logic busy;
    logic done;

    int n_checks = 0;
    int n_fail   = 0;

    signal_encoder #(
        .PERIOD_CYCLES (PERIOD),
        .SAMPLE_POINT  (SAMPLE),
        .SHORT_HIGH    (SHORT),
        .LONG_HIGH     (LONG),
        .REPEAT        (REP),
        .GAP_CYCLES    (GAP)
    ) dut (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .TX_VALID   (tx_valid),
        .TX_BIT     (tx_bit),
        .TX_READY   (tx_ready),
        .AUX_OUTPUT (aux_out),
        .BUSY       (busy),
        .DONE       (done)
    );

    initial forever #5 clk = ~clk;

    int cyc_cnt = 0;
    initial forever begin
        @(posedge clk);
        cyc_cnt++;
    end

    typedef struct {
        bit b;
        int first_rise;
    } exp_t;

    typedef struct {
        int first_rise;
        int pulses;
        int hi_min;
        int hi_max;
        int per_min;
        int per_max;
        int samp_ones;
        int frame_len;
        int rise_after_done;
    } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];

    // ---------------- line monitor (measures, never judges) ----------------
    obs_t cur;
    bit   in_frame    = 1'b0;
    bit   prev_aux    = 1'b0;
    int   last_rise   = 0;
    int   cur_hi      = 0;
    int   last_done_t = -1000;
    int   done_count  = 0;

    initial begin
        int t;
        forever begin
            @(negedge clk);
            t = cyc_cnt;
            if (!rst_n) begin
                in_frame = 1'b0;
                prev_aux = 1'b0;
            end else begin
                if (aux_out && !prev_aux) begin
                    if (!in_frame) begin
                        in_frame            = 1'b1;
                        cur.first_rise      = t;
                        cur.pulses          = 0;
                        cur.hi_min          = 1 << 30;
                        cur.hi_max          = 0;
                        cur.per_min         = 1 << 30;
                        cur.per_max         = 0;
                        cur.samp_ones       = 0;
                        cur.frame_len       = 0;
                        cur.rise_after_done = t - last_done_t;
                    end else begin
                        if (t - last_rise < cur.per_min) cur.per_min = t - last_rise;
                        if (t - last_rise > cur.per_max) cur.per_max = t - last_rise;
                    end
                    last_rise = t;
                    cur.pulses++;
                    cur_hi = 1;
                end else if (aux_out) begin
                    cur_hi++;
                end
                if (!aux_out && prev_aux && in_frame) begin
                    if (cur_hi < cur.hi_min) cur.hi_min = cur_hi;
                    if (cur_hi > cur.hi_max) cur.hi_max = cur_hi;
                end
                if (in_frame && (t - last_rise == SAMPLE) && aux_out) cur.samp_ones++;
                if (done) begin
                    done_count++;
                    last_done_t = t;
                    if (in_frame) begin
                        cur.frame_len = t - cur.first_rise + 1;
                        obs_q.push_back(cur);
                        in_frame = 1'b0;
                    end
                end
                prev_aux = aux_out;
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        tx_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (aux_out !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in: aux=%b done=%b busy=%b ready=%b expected 0 0 0 1",
                     aux_out, done, busy, tx_ready);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (aux_out !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_out: aux=%b done=%b busy=%b ready=%b expected 0 0 0 1",
                     aux_out, done, busy, tx_ready);
        end
        $display("test_reset: done");
    endtask

    task automatic test_single_bit(input bit b);
        exp_t e;
        obs_t o;
        int   done0;
        int   hi_exp;
        done0    = done_count;
        tx_bit   = b;
        tx_valid = 1'b1;
        exp_q.push_back('{b, cyc_cnt + 1});
        @(negedge clk);
        tx_valid = 1'b0;
        n_checks++;
        if (tx_ready !== 1'b0 || busy !== 1'b1 || aux_out !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_b%0d: ready=%b busy=%b aux=%b expected 0 1 1", b, tx_ready, busy, aux_out);
        end
        for (int i = 0; i < 1000 && obs_q.size() == 0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        n_checks++;
        if (obs_q.size() == 0) begin
            n_fail++;
            $display("FAIL frame_timeout_b%0d: got no frame expected 1", b);
        end else begin
            e      = exp_q.pop_front();
            o      = obs_q.pop_front();
            hi_exp = e.b ? LONG : SHORT;
            if (o.first_rise !== e.first_rise || o.pulses !== REP || o.hi_min !== hi_exp ||
                o.hi_max !== hi_exp || o.per_min !== PERIOD || o.per_max !== PERIOD ||
                o.samp_ones !== (e.b ? REP : 0) || o.frame_len !== FRAME) begin
                n_fail++;
                $display("FAIL frame_b%0d: rise=%0d pulses=%0d hi=%0d..%0d per=%0d..%0d samp1=%0d len=%0d expected rise=%0d pulses=%0d hi=%0d per=%0d samp1=%0d len=%0d",
                         b, o.first_rise, o.pulses, o.hi_min, o.hi_max, o.per_min, o.per_max,
                         o.samp_ones, o.frame_len, e.first_rise, REP, hi_exp, PERIOD,
                         e.b ? REP : 0, FRAME);
            end
        end
        n_checks++;
        if (done_count - done0 !== 1 || tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL done_once_b%0d: done_cycles=%0d ready=%b expected 1 1", b, done_count - done0, tx_ready);
        end
        $display("test_single_bit(%0d): done", b);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        obs_t o;
        int   r;
        int   t;
        int   busy_ready = 0;
        bit   idle_ready = 1'b0;
        tx_bit   = 1'b1;
        tx_valid = 1'b1;
        r = cyc_cnt + 1;
        exp_q.push_back('{1'b1, r});
        // Second frame is taken in the single IDLE cycle after DONE.
        exp_q.push_back('{1'b0, r + FRAME + 1});
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            t = cyc_cnt;
            if (t >= r && t <= r + FRAME - 1 && tx_ready !== 1'b0) busy_ready++;
            if (t == r + FRAME && tx_ready === 1'b1) idle_ready = 1'b1;
            if (t == r + 100) tx_bit = 1'b0;
            if (t == r + FRAME + 5) tx_valid = 1'b0;
        end
        n_checks++;
        if (busy_ready !== 0 || idle_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: ready_in_frame=%0d idle_ready=%b expected 0 1", busy_ready, idle_ready);
        end
        for (int i = 0; i < 1000 && obs_q.size() < 2; i++) @(negedge clk);
        n_checks++;
        if (obs_q.size() < 2) begin
            n_fail++;
            $display("FAIL b2b_timeout: got %0d frames expected 2", obs_q.size());
        end else begin
            for (int f = 0; f < 2; f++) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                n_checks++;
                if (o.first_rise !== e.first_rise || o.pulses !== REP ||
                    o.hi_min !== (e.b ? LONG : SHORT) || o.hi_max !== (e.b ? LONG : SHORT) ||
                    o.samp_ones !== (e.b ? REP : 0) || o.frame_len !== FRAME ||
                    (f == 1 && o.rise_after_done !== 2)) begin
                    n_fail++;
                    $display("FAIL b2b_frame%0d: rise=%0d pulses=%0d hi=%0d..%0d samp1=%0d len=%0d gap_to_done=%0d expected rise=%0d pulses=%0d hi=%0d samp1=%0d len=%0d gap_to_done=2",
                             f, o.first_rise, o.pulses, o.hi_min, o.hi_max, o.samp_ones,
                             o.frame_len, o.rise_after_done, e.first_rise, REP,
                             e.b ? LONG : SHORT, e.b ? REP : 0, FRAME);
                end
            end
        end
        repeat (5) @(negedge clk);
        $display("test_back_to_back: done");
    endtask

    task automatic test_reset_mid_frame();
        int  done0;
        int  aux_hi = 0;
        bit  reached = 1'b0;
        done0    = done_count;
        tx_bit   = 1'b1;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int i = 0; i < 500 && !reached; i++) begin
            @(negedge clk);
            if (in_frame && cur.pulses == 3 && aux_out && cur_hi >= 5) reached = 1'b1;
        end
        n_checks++;
        if (!reached) begin
            n_fail++;
            $display("FAIL mid_reach: third pulse seen=%b expected 1", reached);
        end
        // Assert reset between edges: the line must drop with no clock edge.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (aux_out !== 1'b0 || tx_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async: aux=%b ready=%b done=%b expected 0 1 0", aux_out, tx_ready, done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_release: ready=%b busy=%b expected 1 0", tx_ready, busy);
        end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (aux_out) aux_hi++;
        end
        n_checks++;
        if (done_count !== done0 || obs_q.size() !== 0 || aux_hi !== 0) begin
            n_fail++;
            $display("FAIL mid_abort: done_cycles=%0d frames=%0d aux_high=%0d expected 0 0 0",
                     done_count - done0, obs_q.size(), aux_hi);
        end
        $display("test_reset_mid_frame: done");
    endtask

    initial begin
        test_reset();
        test_single_bit(1'b1);
        test_single_bit(1'b0);
        test_back_to_back();
        test_reset_mid_frame();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: left=%0d expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit in case a wait is never satisfied.
    initial begin
        #200000;
        $display("FAIL watchdog: time=%0t expected finish before 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
